// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared types and helpers for the seven-segment display blocks.
package hex_disp_pkg;
    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_W      = NIBBLE_W * MAX_DIGITS;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Bit i set when nibbles i..n-1 of v are all zero.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_W-1:0] v, input int n);
        logic [MAX_DIGITS-1:0] m;
        logic z;
        m = '0;
        z = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < n) begin
                z = z && (v[NIBBLE_W*i +: NIBBLE_W] == '0);
                m[i] = z;
            end
        end
        return m;
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..DIV-1 counter emitting a one-cycle dwell tick.
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q;

    assign tick = cnt_q == W'(DIV - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: multiplexed digit scanner with tear-free loads and leading-zero blanking.
module hex_scan_driver
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_valid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
    output logic                           load_ready,
    output nibble_t                        digit_val,
    output logic [NUM_DIGITS-1:0]          digit_sel_n,
    output logic                           digit_blank,
    output logic                           frame_done
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = NIBBLE_W * NUM_DIGITS;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    logic                  tick, wrap, accept;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d, pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    nibble_t               val_q, val_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  blank_q, blank_d, done_q;
    logic [MAX_DIGITS-1:0] lz;

    scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Outputs are computed from next-state so they move on the same edge as idx/shadow.
    always_comb begin
        wrap        = tick && idx_q == LAST;
        accept      = load_valid && !pend_full_q;
        idx_d       = tick ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q;
        shadow_d    = (wrap && pend_full_q) ? pend_q : shadow_q;
        pend_d      = accept ? load_data : pend_q;
        pend_full_d = accept || (pend_full_q && !wrap);
        lz          = lz_mask(MAX_W'(shadow_d), NUM_DIGITS);
        val_d       = shadow_d[NIBBLE_W*idx_d +: NIBBLE_W];
        sel_d       = ~(NUM_DIGITS'(1) << idx_d);
        blank_d     = LZ_BLANK != 0 && idx_d != '0 && lz[idx_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            shadow_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            val_q       <= '0;
            sel_q       <= ~NUM_DIGITS'(1);
            blank_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            val_q       <= val_d;
            sel_q       <= sel_d;
            blank_q     <= blank_d;
            done_q      <= wrap;
        end
    end

    assign load_ready  = !pend_full_q;
    assign digit_val   = val_q;
    assign digit_sel_n = sel_q;
    assign digit_blank = blank_q;
    assign frame_done  = done_q;
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: checks three scanner configurations against an edge-count model
// plus hand-computed checkpoints.
module tb_hex_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0, load_valid_c = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  load_data_c = '0;

    logic       rdy_a, blank_a, done_a, rdy_b, blank_b, done_b, rdy_c, blank_c, done_c;
    logic [3:0] val_a, sel_a, val_b, sel_b, val_c;
    logic [0:0] sel_c;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hex_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1)) dut_a (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_a), .digit_val(val_a), .digit_sel_n(sel_a),
        .digit_blank(blank_a), .frame_done(done_a));

    hex_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(0)) dut_b (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_b), .digit_val(val_b), .digit_sel_n(sel_b),
        .digit_blank(blank_b), .frame_done(done_b));

    hex_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(2), .LZ_BLANK(1)) dut_c (
        .clk(clk), .reset(reset), .load_valid(load_valid_c), .load_data(load_data_c),
        .load_ready(rdy_c), .digit_val(val_c), .digit_sel_n(sel_c),
        .digit_blank(blank_c), .frame_done(done_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: edges since reset give the digit index; loads sit in a one-deep queue until a frame boundary.
    int          k = 0, kc = 0;
    logic [15:0] sh = '0;
    logic [3:0]  shc = '0;
    logic [15:0] pend[$];
    logic [3:0]  pendc[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k = 0; kc = 0; sh = '0; shc = '0;
            pend.delete(); pendc.delete();
        end else begin
            automatic bit ra = pend.size() == 0;
            automatic bit rc = pendc.size() == 0;
            k++; kc++;
            if (k % 16 == 0 && !ra) sh = pend.pop_front();
            if (load_valid && ra) pend.push_back(load_data);
            if (kc % 2 == 0 && !rc) shc = pendc.pop_front();
            if (load_valid_c && rc) pendc.push_back(load_data_c);
        end
    end

    always @(negedge clk) begin
        automatic int         idx = (k / 4) % 4;
        automatic logic [15:0] rest = sh >> (4 * idx);
        automatic logic [3:0] e_sel = ~(4'b0001 << idx);
        automatic logic       e_done = k > 0 && k % 16 == 0;
        chk("a_sel", sel_a, e_sel);
        chk("a_val", val_a, rest[3:0]);
        chk("a_blank", blank_a, idx != 0 && rest == 0);
        chk("a_done", done_a, e_done);
        chk("a_ready", rdy_a, pend.size() == 0);
        chk("b_sel", sel_b, e_sel);
        chk("b_val", val_b, rest[3:0]);
        chk("b_blank", blank_b, 0);
        chk("b_done", done_b, e_done);
        chk("c_sel", sel_c, 0);
        chk("c_val", val_c, shc);
        chk("c_blank", blank_c, 0);
        chk("c_done", done_c, kc > 0 && kc % 2 == 0);
        chk("c_ready", rdy_c, pendc.size() == 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk("t1_rst_sel", sel_a, 4'b1110);
        chk("t1_rst_val", val_a, 0);
        chk("t1_rst_blank", blank_a, 0);
        chk("t1_rst_ready", rdy_a, 1);
        step(4);
        chk("t1_sel_d1", sel_a, 4'b1101);
        chk("t1_blank_d1", blank_a, 1);
        step(12);
        chk("t1_wrap_done", done_a, 1);
        chk("t1_wrap_sel", sel_a, 4'b1110);
        load_valid = 1'b1; load_data = 16'h1234;
        step(1);
        load_valid = 1'b0;
        chk("t2_ready_low", rdy_a, 0);
        chk("t2_done_once", done_a, 0);
        chk("t2_old_val", val_a, 0);
        step(15);
        chk("t2_commit_val", val_a, 4'h4);
        chk("t2_ready_back", rdy_a, 1);
        step(4);
        chk("t2_d1_val", val_a, 4'h3);
        step(8);
        chk("t2_d3_val", val_a, 4'h1);
        chk("t2_d3_sel", sel_a, 4'b0111);
        chk("t2_d3_blank", blank_a, 0);
        load_valid = 1'b1; load_data = 16'h5678;
        step(1);
        load_data = 16'hABCD;
        chk("t3_full", rdy_a, 0);
        for (int i = 0; i < 40 && !rdy_a; i++) step(1);
        chk("t3_ready_wait", rdy_a, 1);
        chk("t3_first_val", val_a, 4'h8);
        step(1);
        load_valid = 1'b0;
        chk("t3_second_taken", rdy_a, 0);
        step(15);
        chk("t3_second_val", val_a, 4'hD);
        chk("t3_ready", rdy_a, 1);
        load_valid = 1'b1; load_data = 16'h0050;
        step(1);
        load_valid = 1'b0;
        step(15);
        chk("t4_d0_val", val_a, 0);
        chk("t4_d0_blank", blank_a, 0);
        step(4);
        chk("t4_d1_val", val_a, 4'h5);
        chk("t4_d1_blank", blank_a, 0);
        step(4);
        chk("t4_d2_blank", blank_a, 1);
        chk("t4_d2_noblank", blank_b, 0);
        load_valid = 1'b1; load_data = 16'h0000;
        step(1);
        load_valid = 1'b0;
        step(11);
        chk("t4_zero_d1_blank", blank_a, 1);
        step(4);
        chk("t4_zero_d2_blank", blank_a, 1);
        chk("t4_zero_d2_sel", sel_a, 4'b1011);
        load_valid = 1'b1; load_data = 16'h9999;
        step(1);
        load_valid = 1'b0;
        chk("t5_pending", rdy_a, 0);
        step(1);
        #1 reset = 1'b1;
        #2;
        chk("t5_rst_sel", sel_a, 4'b1110);
        chk("t5_rst_val", val_a, 0);
        chk("t5_rst_ready", rdy_a, 1);
        chk("t5_rst_done", done_a, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(16);
        chk("t5_discarded", val_a, 0);
        chk("t5_wrap_done", done_a, 1);
        load_valid_c = 1'b1; load_data_c = 4'h7;
        step(1);
        load_valid_c = 1'b0;
        chk("t6_ready_low", rdy_c, 0);
        chk("t6_old_val", val_c, 0);
        step(1);
        chk("t6_commit", val_c, 4'h7);
        chk("t6_ready_back", rdy_c, 1);
        chk("t6_done", done_c, 1);
        chk("t6_sel", sel_c, 0);
        step(1);
        chk("t6_done_low", done_c, 0);
        load_valid_c = 1'b1; load_data_c = 4'h3;
        step(1);
        load_valid_c = 1'b0;
        chk("t6_wrap_load_hold", val_c, 4'h7);
        chk("t6_wrap_load_full", rdy_c, 0);
        step(2);
        chk("t6_wrap_load_commit", val_c, 4'h3);
        chk("t6_wrap_load_ready", rdy_c, 1);
        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
